// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for the 5-stage RV32IM pipeline.
// Define HAZARD_PERF_CNT_EN to add the STALL_CYCLES/FLUSH_EVENTS/MULDIV_CYCLES counters.
module pipeline_hazard_controller #(
    parameter int MULDIV_TIMEOUT = 64,
    parameter int PERF_CNT_WIDTH = 32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] ID_RS1_ADDR,
    input  logic [4:0] ID_RS2_ADDR,
    input  logic       ID_USES_RS1,
    input  logic       ID_USES_RS2,
    input  logic [4:0] EX_RD_ADDR,
    input  logic       EX_MEM_READ,
    input  logic       EX_MULDIV,
    input  logic       MULDIV_DONE,
    input  logic       BRANCH_TAKEN,
    input  logic       IMEM_BUSY,
    input  logic       DMEM_BUSY,
    output logic       PC_HOLD,
    output logic       IF_ID_HOLD,
    output logic       IF_ID_FLUSH,
    output logic       ID_EX_HOLD,
    output logic       ID_EX_BUBBLE,
    output logic       EX_MEM_HOLD,
    output logic       EX_MEM_BUBBLE,
    output logic       MEM_WB_BUBBLE,
    output logic       MULDIV_START,
    output logic       MULDIV_ERR
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] STALL_CYCLES,
    output logic [PERF_CNT_WIDTH-1:0] FLUSH_EVENTS,
    output logic [PERF_CNT_WIDTH-1:0] MULDIV_CYCLES
`endif
);
    typedef enum logic [1:0] {RUN, MULDIV_WAIT, MEM_WAIT} state_t;

    state_t      state_q, state_d;
    logic        redirect_q, redirect_d;
    logic [9:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic        load_use;
    logic [9:0]  wait_inc;

    assign load_use = EX_MEM_READ && (EX_RD_ADDR != 5'd0) &&
                      ((ID_USES_RS1 && ID_RS1_ADDR == EX_RD_ADDR) ||
                       (ID_USES_RS2 && ID_RS2_ADDR == EX_RD_ADDR));
    assign wait_inc = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 10'd1;
    assign MULDIV_ERR = err_q && !RESET;

    always_comb begin
        PC_HOLD       = 1'b0;
        IF_ID_HOLD    = 1'b0;
        IF_ID_FLUSH   = 1'b0;
        ID_EX_HOLD    = 1'b0;
        ID_EX_BUBBLE  = 1'b0;
        EX_MEM_HOLD   = 1'b0;
        EX_MEM_BUBBLE = 1'b0;
        MEM_WB_BUBBLE = 1'b0;
        MULDIV_START  = 1'b0;
        state_d       = state_q;
        redirect_d    = redirect_q;
        wait_cnt_d    = wait_cnt_q;
        err_d         = err_q || (state_q == MULDIV_WAIT && wait_cnt_q == 10'(MULDIV_TIMEOUT));
        if (RESET) begin
            IF_ID_FLUSH   = 1'b1;
            ID_EX_BUBBLE  = 1'b1;
            EX_MEM_BUBBLE = 1'b1;
            MEM_WB_BUBBLE = 1'b1;
            state_d       = RUN;
            redirect_d    = 1'b0;
            wait_cnt_d    = 10'd0;
            err_d         = 1'b0;
        end else if (DMEM_BUSY) begin
            PC_HOLD       = 1'b1;
            IF_ID_HOLD    = 1'b1;
            ID_EX_HOLD    = 1'b1;
            EX_MEM_HOLD   = 1'b1;
            MEM_WB_BUBBLE = 1'b1;
            if (state_q == MULDIV_WAIT) wait_cnt_d = wait_inc;
            else state_d = MEM_WAIT;
        end else if (state_q == MULDIV_WAIT && !MULDIV_DONE) begin
            PC_HOLD       = 1'b1;
            IF_ID_HOLD    = 1'b1;
            ID_EX_HOLD    = 1'b1;
            EX_MEM_BUBBLE = 1'b1;
            wait_cnt_d    = wait_inc;
        end else if (state_q != MULDIV_WAIT && EX_MULDIV) begin
            MULDIV_START  = 1'b1;
            PC_HOLD       = 1'b1;
            IF_ID_HOLD    = 1'b1;
            ID_EX_HOLD    = 1'b1;
            EX_MEM_BUBBLE = 1'b1;
            state_d       = MULDIV_WAIT;
            wait_cnt_d    = 10'd1;
        end else begin
            // RUN, a MEM_WAIT exit, or a muldiv release cycle: the front end resolves normally
            state_d    = RUN;
            wait_cnt_d = 10'd0;
            if (BRANCH_TAKEN) begin
                IF_ID_FLUSH  = 1'b1;
                ID_EX_BUBBLE = 1'b1;
                redirect_d   = IMEM_BUSY;
            end else begin
                PC_HOLD      = load_use || IMEM_BUSY;
                IF_ID_HOLD   = load_use;
                ID_EX_BUBBLE = load_use;
                IF_ID_FLUSH  = !load_use && (IMEM_BUSY || redirect_q);
                redirect_d   = redirect_q && (IMEM_BUSY || load_use);
            end
        end
    end

    always_ff @(posedge CLK) begin
        state_q    <= state_d;
        redirect_q <= redirect_d;
        wait_cnt_q <= wait_cnt_d;
        err_q      <= err_d;
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            STALL_CYCLES  <= '0;
            FLUSH_EVENTS  <= '0;
            MULDIV_CYCLES <= '0;
        end else begin
            STALL_CYCLES  <= STALL_CYCLES + PERF_CNT_WIDTH'(PC_HOLD);
            FLUSH_EVENTS  <= FLUSH_EVENTS + PERF_CNT_WIDTH'(IF_ID_FLUSH && ID_EX_BUBBLE);
            MULDIV_CYCLES <= MULDIV_CYCLES + PERF_CNT_WIDTH'(state_q == MULDIV_WAIT);
        end
    end
`else
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed checks of the hazard controller, default and short-timeout instances.
module tb_pipeline_hazard_controller;
    logic CLK = 1'b0, RESET = 1'b0;
    logic [4:0] ID_RS1_ADDR, ID_RS2_ADDR, EX_RD_ADDR;
    logic ID_USES_RS1, ID_USES_RS2, EX_MEM_READ, EX_MULDIV, MULDIV_DONE;
    logic BRANCH_TAKEN, IMEM_BUSY, DMEM_BUSY;
    logic [9:0] o, t;
    int n_pass = 0, n_total = 0;

    // {PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_BUBBLE, EX_MEM_HOLD, EX_MEM_BUBBLE, MEM_WB_BUBBLE, START, ERR}
    localparam logic [9:0] RST_V   = 10'b0010101100;
    localparam logic [9:0] DMEM_V  = 10'b1101010100;
    localparam logic [9:0] START_V = 10'b1101001010;
    localparam logic [9:0] WAIT_V  = 10'b1101001000;
    localparam logic [9:0] LU_V    = 10'b1100100000;
    localparam logic [9:0] BR_V    = 10'b0010100000;
    localparam logic [9:0] IBUSY_V = 10'b1010000000;
    localparam logic [9:0] RET_V   = 10'b0010000000;

    always #5 CLK = ~CLK;

    pipeline_hazard_controller u_dut (
        .CLK(CLK), .RESET(RESET), .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2), .EX_RD_ADDR(EX_RD_ADDR),
        .EX_MEM_READ(EX_MEM_READ), .EX_MULDIV(EX_MULDIV), .MULDIV_DONE(MULDIV_DONE),
        .BRANCH_TAKEN(BRANCH_TAKEN), .IMEM_BUSY(IMEM_BUSY), .DMEM_BUSY(DMEM_BUSY),
        .PC_HOLD(o[9]), .IF_ID_HOLD(o[8]), .IF_ID_FLUSH(o[7]), .ID_EX_HOLD(o[6]),
        .ID_EX_BUBBLE(o[5]), .EX_MEM_HOLD(o[4]), .EX_MEM_BUBBLE(o[3]), .MEM_WB_BUBBLE(o[2]),
        .MULDIV_START(o[1]), .MULDIV_ERR(o[0]));

    pipeline_hazard_controller #(.MULDIV_TIMEOUT(8)) u_t8 (
        .CLK(CLK), .RESET(RESET), .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2), .EX_RD_ADDR(EX_RD_ADDR),
        .EX_MEM_READ(EX_MEM_READ), .EX_MULDIV(EX_MULDIV), .MULDIV_DONE(MULDIV_DONE),
        .BRANCH_TAKEN(BRANCH_TAKEN), .IMEM_BUSY(IMEM_BUSY), .DMEM_BUSY(DMEM_BUSY),
        .PC_HOLD(t[9]), .IF_ID_HOLD(t[8]), .IF_ID_FLUSH(t[7]), .ID_EX_HOLD(t[6]),
        .ID_EX_BUBBLE(t[5]), .EX_MEM_HOLD(t[4]), .EX_MEM_BUBBLE(t[3]), .MEM_WB_BUBBLE(t[2]),
        .MULDIV_START(t[1]), .MULDIV_ERR(t[0]));

    task automatic idle_inputs();
        {ID_RS1_ADDR, ID_RS2_ADDR, EX_RD_ADDR} = '0;
        {ID_USES_RS1, ID_USES_RS2, EX_MEM_READ, EX_MULDIV, MULDIV_DONE} = '0;
        {BRANCH_TAKEN, IMEM_BUSY, DMEM_BUSY} = '0;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_load_use();
        EX_MEM_READ = 1'b1; EX_RD_ADDR = 5'd5; ID_RS1_ADDR = 5'd5; ID_USES_RS1 = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET = 1'b1;
        #1;
        n_total++; if (o !== RST_V) $display("FAIL reset_out got=%b exp=%b", o, RST_V); else n_pass++;
        cyc();
        RESET = 1'b0;
        #1;
        n_total++; if (o !== 10'b0) $display("FAIL reset_idle got=%b exp=%b", o, 10'b0); else n_pass++;
        cyc();
    endtask

    task automatic test_load_use();
        set_load_use();
        #1;
        n_total++; if (o !== LU_V) $display("FAIL load_use_rs1 got=%b exp=%b", o, LU_V); else n_pass++;
        cyc();
        EX_MEM_READ = 1'b0;
        #1;
        n_total++; if (o !== 10'b0) $display("FAIL load_use_after got=%b exp=%b", o, 10'b0); else n_pass++;
        cyc();
        EX_MEM_READ = 1'b1; EX_RD_ADDR = 5'd0; ID_RS1_ADDR = 5'd0;
        #1;
        n_total++; if (o !== 10'b0) $display("FAIL load_use_rd0 got=%b exp=%b", o, 10'b0); else n_pass++;
        cyc();
        EX_RD_ADDR = 5'd7; ID_RS1_ADDR = 5'd7; ID_USES_RS1 = 1'b0;
        #1;
        n_total++; if (o !== 10'b0) $display("FAIL load_use_unused got=%b exp=%b", o, 10'b0); else n_pass++;
        cyc();
        ID_RS2_ADDR = 5'd7; ID_USES_RS2 = 1'b1;
        #1;
        n_total++; if (o !== LU_V) $display("FAIL load_use_rs2 got=%b exp=%b", o, LU_V); else n_pass++;
        cyc();
        idle_inputs();
        #1;
        n_total++; if (o !== 10'b0) $display("FAIL load_use_rs2_after got=%b exp=%b", o, 10'b0); else n_pass++;
        cyc();
    endtask

    task automatic test_divide();
        int holds = 0;
        EX_MULDIV = 1'b1;
        #1;
        n_total++; if (o !== START_V) $display("FAIL div_start got=%b exp=%b", o, START_V); else n_pass++;
        holds += int'(o[9]);
        cyc();
        for (int i = 1; i <= 33; i++) begin
            #1;
            n_total++; if (o !== WAIT_V) $display("FAIL div_wait%0d got=%b exp=%b", i, o, WAIT_V); else n_pass++;
            holds += int'(o[9]);
            cyc();
        end
        MULDIV_DONE = 1'b1;
        #1;
        n_total++; if (o !== 10'b0) $display("FAIL div_release got=%b exp=%b", o, 10'b0); else n_pass++;
        holds += int'(o[9]);
        n_total++; if (holds !== 34) $display("FAIL div_hold_cycles got=%0d exp=34", holds); else n_pass++;
        cyc();
        EX_MULDIV = 1'b0;
        #1;
        n_total++; if (o !== 10'b0) $display("FAIL div_after got=%b exp=%b", o, 10'b0); else n_pass++;
        cyc();
        idle_inputs();
    endtask

    task automatic test_timeout();
        idle_inputs();
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        EX_MULDIV = 1'b1;
        #1;
        n_total++; if (t !== START_V) $display("FAIL to_start got=%b exp=%b", t, START_V); else n_pass++;
        cyc();
        for (int k = 1; k <= 8; k++) begin
            #1;
            n_total++; if (t !== WAIT_V) $display("FAIL to_wait%0d got=%b exp=%b", k, t, WAIT_V); else n_pass++;
            cyc();
        end
        for (int k = 9; k <= 10; k++) begin
            #1;
            n_total++; if (t !== (WAIT_V | 10'b1)) $display("FAIL to_err%0d got=%b exp=%b", k, t, WAIT_V | 10'b1); else n_pass++;
            cyc();
        end
        RESET = 1'b1;
        #1;
        n_total++; if (t !== RST_V) $display("FAIL to_reset got=%b exp=%b", t, RST_V); else n_pass++;
        cyc();
        RESET = 1'b0;
        EX_MULDIV = 1'b0;
        #1;
        n_total++; if (t !== 10'b0) $display("FAIL to_after_reset got=%b exp=%b", t, 10'b0); else n_pass++;
        cyc();
        EX_MULDIV = 1'b1;
        #1;
        n_total++; if (t !== START_V) $display("FAIL to_restart got=%b exp=%b", t, START_V); else n_pass++;
        cyc();
        MULDIV_DONE = 1'b1;
        #1;
        n_total++; if (t !== 10'b0) $display("FAIL to_release got=%b exp=%b", t, 10'b0); else n_pass++;
        cyc();
        idle_inputs();
    endtask

    task automatic test_branch_fetch();
        BRANCH_TAKEN = 1'b1; IMEM_BUSY = 1'b1;
        #1;
        n_total++; if (o !== BR_V) $display("FAIL br_cycle1 got=%b exp=%b", o, BR_V); else n_pass++;
        cyc();
        BRANCH_TAKEN = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            #1;
            n_total++; if (o !== IBUSY_V) $display("FAIL br_cycle%0d got=%b exp=%b", c, o, IBUSY_V); else n_pass++;
            cyc();
        end
        IMEM_BUSY = 1'b0;
        #1;
        n_total++; if (o !== RET_V) $display("FAIL br_return got=%b exp=%b", o, RET_V); else n_pass++;
        cyc();
        #1;
        n_total++; if (o !== 10'b0) $display("FAIL br_cleared got=%b exp=%b", o, 10'b0); else n_pass++;
        set_load_use();
        BRANCH_TAKEN = 1'b1;
        #1;
        n_total++; if (o !== BR_V) $display("FAIL br_over_load_use got=%b exp=%b", o, BR_V); else n_pass++;
        cyc();
        idle_inputs();
        #1;
        n_total++; if (o !== 10'b0) $display("FAIL br_no_pend got=%b exp=%b", o, 10'b0); else n_pass++;
        cyc();
    endtask

    task automatic test_imem_busy();
        IMEM_BUSY = 1'b1;
        #1;
        n_total++; if (o !== IBUSY_V) $display("FAIL imem_busy got=%b exp=%b", o, IBUSY_V); else n_pass++;
        cyc();
        IMEM_BUSY = 1'b0;
        #1;
        n_total++; if (o !== 10'b0) $display("FAIL imem_done got=%b exp=%b", o, 10'b0); else n_pass++;
        cyc();
    endtask

    task automatic test_dmem_load_use();
        set_load_use();
        DMEM_BUSY = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            #1;
            n_total++; if (o !== DMEM_V) $display("FAIL dmem_hold%0d got=%b exp=%b", c, o, DMEM_V); else n_pass++;
            cyc();
        end
        DMEM_BUSY = 1'b0;
        #1;
        n_total++; if (o !== LU_V) $display("FAIL dmem_then_load_use got=%b exp=%b", o, LU_V); else n_pass++;
        cyc();
        EX_MEM_READ = 1'b0;
        #1;
        n_total++; if (o !== 10'b0) $display("FAIL dmem_after got=%b exp=%b", o, 10'b0); else n_pass++;
        cyc();
        idle_inputs();
    endtask

    task automatic test_reset_mem_wait();
        DMEM_BUSY = 1'b1;
        cyc();
        RESET = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            #1;
            n_total++; if (o !== RST_V) $display("FAIL mw_reset%0d got=%b exp=%b", c, o, RST_V); else n_pass++;
            cyc();
        end
        RESET = 1'b0; DMEM_BUSY = 1'b0; EX_MULDIV = 1'b1;
        #1;
        n_total++; if (o !== START_V) $display("FAIL mw_run_after got=%b exp=%b", o, START_V); else n_pass++;
        cyc();
        DMEM_BUSY = 1'b1;
        #1;
        n_total++; if (o !== DMEM_V) $display("FAIL mw_dmem_in_div got=%b exp=%b", o, DMEM_V); else n_pass++;
        cyc();
        DMEM_BUSY = 1'b0; MULDIV_DONE = 1'b1;
        #1;
        n_total++; if (o !== 10'b0) $display("FAIL mw_div_release got=%b exp=%b", o, 10'b0); else n_pass++;
        cyc();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_divide();
        test_timeout();
        test_branch_fetch();
        test_imem_busy();
        test_dmem_load_use();
        test_reset_mem_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RV32IM pipeline. It drives hold and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch redirects, multi-cycle M-extension operations and instruction/data memory wait states into one consistent per-cycle control set. The FSM and flags are registered; all control outputs are combinational from the registered state plus the current inputs.

Parameters:
MULDIV_TIMEOUT, 64, max cycles in MULDIV_WAIT before MULDIV_ERR asserts; range 2..1023.
PERF_CNT_WIDTH, 32, width of the performance counters (optional feature only).

Ports:
CLK  in  1  clock; all state updates on posedge.
RESET  in  1  synchronous, active-high.
ID_RS1_ADDR  in  5  rs1 of the instruction in ID.
ID_RS2_ADDR  in  5  rs2 of the instruction in ID.
ID_USES_RS1  in  1  ID instruction reads rs1.
ID_USES_RS2  in  1  ID instruction reads rs2.
EX_RD_ADDR  in  5  rd of the instruction in EX.
EX_MEM_READ  in  1  EX instruction is a load.
EX_MULDIV  in  1  EX instruction is MUL/DIV/REM class.
MULDIV_DONE  in  1  muldiv result valid; level, held until next MULDIV_START.
BRANCH_TAKEN  in  1  branch/jump resolved taken in EX.
IMEM_BUSY  in  1  instruction fetch not yet returned.
DMEM_BUSY  in  1  data access in MEM not complete.
PC_HOLD  out  1  PC keeps its value.
IF_ID_HOLD  out  1  IF/ID keeps its contents.
IF_ID_FLUSH  out  1  IF/ID loads NOP (0x00000013) and PC 0.
ID_EX_HOLD  out  1  ID/EX keeps its contents.
ID_EX_BUBBLE  out  1  ID/EX loads all-zero control.
EX_MEM_HOLD  out  1  EX/MEM keeps its contents.
EX_MEM_BUBBLE  out  1  EX/MEM loads all-zero control.
MEM_WB_BUBBLE  out  1  MEM/WB loads all-zero control.
MULDIV_START  out  1  one-cycle start pulse to the muldiv unit.
MULDIV_ERR  out  1  sticky timeout flag; cleared only by RESET.

Behaviour:
- States: RUN, MULDIV_WAIT, MEM_WAIT. Flag REDIRECT_PEND. Counter WAIT_CNT (10 bits).
- RESET high: next state RUN; REDIRECT_PEND=0; WAIT_CNT=0; MULDIV_ERR=0.
- RESET high, outputs in the same cycle: IF_ID_FLUSH=1, ID_EX_BUBBLE=1, EX_MEM_BUBBLE=1, MEM_WB_BUBBLE=1; all other outputs 0.
- Reset mid-operation (any state) aborts it. No MULDIV_START is issued.
- Priority, highest first: DMEM_BUSY > MULDIV_WAIT/EX_MULDIV > BRANCH_TAKEN > load-use > IMEM_BUSY.
- DMEM_BUSY=1 in any state:
  - Outputs: PC_HOLD, IF_ID_HOLD, ID_EX_HOLD and EX_MEM_HOLD all 1; MEM_WB_BUBBLE=1.
  - All other outputs 0, including MULDIV_START.
  - From RUN, next state is MEM_WAIT.
  - In MULDIV_WAIT the state is kept and WAIT_CNT still counts.
- MEM_WAIT: returns to RUN on the first cycle DMEM_BUSY=0. That cycle is evaluated as RUN, so there is zero added latency.
- RUN with EX_MULDIV=1:
  - Assert MULDIV_START for exactly this cycle.
  - Outputs: PC_HOLD, IF_ID_HOLD and ID_EX_HOLD all 1; EX_MEM_BUBBLE=1.
  - Next state MULDIV_WAIT; WAIT_CNT=1.
- MULDIV_WAIT:
  - While MULDIV_DONE=0: same hold/bubble set as above with no START; WAIT_CNT increments and saturates.
  - WAIT_CNT==MULDIV_TIMEOUT sets MULDIV_ERR. Stalling continues; there is no forced release.
  - On MULDIV_DONE=1 with DMEM_BUSY=0: all holds 0 and EX_MEM_BUBBLE=0, so EX/MEM captures the result. Next state RUN; WAIT_CNT=0.
  - The released instruction leaves EX, so no re-START is possible.
- RUN with BRANCH_TAKEN=1 (and not muldiv):
  - Outputs: IF_ID_FLUSH=1 and ID_EX_BUBBLE=1; PC not held, so PC loads the target.
  - If IMEM_BUSY=1 in the same cycle, set REDIRECT_PEND, because the in-flight fetch is wrong-path.
- REDIRECT_PEND=1: IF_ID_FLUSH=1 every cycle, plus PC_HOLD=1 while IMEM_BUSY=1. The flag clears on the first cycle IMEM_BUSY=0; the instruction returned that cycle is squashed.
- Load-use in RUN:
  - Condition: EX_MEM_READ=1, EX_RD_ADDR≠0, and (ID_USES_RS1 with rs1==rd, or ID_USES_RS2 with rs2==rd).
  - Outputs: PC_HOLD=1, IF_ID_HOLD=1, ID_EX_BUBBLE=1 for exactly one cycle; the bubble removes the condition.
- IMEM_BUSY alone in RUN: PC_HOLD=1 and IF_ID_FLUSH=1; downstream stages advance.
- HOLD and FLUSH/BUBBLE are never both 1 on the same register; HOLD wins.
- Branch together with load-use: branch wins and no hold is applied.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: adds output ports STALL_CYCLES, FLUSH_EVENTS and MULDIV_CYCLES, each PERF_CNT_WIDTH wide.
  - STALL_CYCLES increments on any cycle with PC_HOLD=1.
  - FLUSH_EVENTS increments per BRANCH_TAKEN flush.
  - MULDIV_CYCLES increments per cycle in MULDIV_WAIT.
  - All three wrap modulo 2^PERF_CNT_WIDTH and are zeroed by RESET.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: EX lw x5 (EX_MEM_READ=1, EX_RD_ADDR=5), ID add rs1=5 -> exactly 1 cycle of PC_HOLD=1, IF_ID_HOLD=1, ID_EX_BUBBLE=1, then all 0. Repeat with rd=0 -> no stall.
- Divide: EX_MULDIV=1, MULDIV_DONE rises 33 cycles after START -> START pulse is 1 cycle; holds active for 34 cycles total; release on the DONE cycle; MULDIV_ERR=0.
- Timeout: MULDIV_TIMEOUT=8, DONE never asserts -> MULDIV_ERR=1 after 8 cycles in MULDIV_WAIT and stays 1. RESET mid-wait -> state RUN, ERR=0, START not re-pulsed.
- Branch during fetch: BRANCH_TAKEN=1 while IMEM_BUSY=1 for 3 more cycles -> IF_ID_FLUSH=1 on all 4 cycles plus the return cycle; PC_HOLD=1 on cycles 2-4 only.
- DMEM_BUSY for 5 cycles coincident with a load-use hazard -> 5 cycles of full hold with MEM_WB_BUBBLE=1, then 1 load-use bubble cycle.
- Reset: RESET=1 for 2 cycles mid-MEM_WAIT -> IF_ID_FLUSH=1, all bubbles 1, all holds 0; state RUN after release.
